des_expand_mix: RTL and testbench

- DES round-function front end; sits directly upstream of the eight S-box lookups (s1..s8).
- Applies expansion permutation E to the 32-bit right half and XORs the result with the 48-bit round subkey.
- Presents eight 6-bit raw S-box indices through a registered valid/ready stage with a one-entry skid buffer.
- Tags each output with its round index.

---
 rtl/des_pkg.sv | 35 +++
 rtl/des_skid_reg.sv | 67 ++++++
 rtl/des_expand_mix.sv | 82 ++++++++
 tb/tb_des_expand_mix.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES expansion/key-mix front end.
// DES_EXPAND_MIX_PARITY_EN adds per-chunk parity to the beat payload.
package des_pkg;

    localparam int unsigned R_WIDTH     = 32;
    localparam int unsigned K_WIDTH     = 48;
    localparam int unsigned CHUNK_WIDTH = 6;
    localparam int unsigned NUM_CHUNKS  = K_WIDTH / CHUNK_WIDTH;
    localparam int unsigned NUM_ROUNDS  = 16;
    localparam int unsigned ROUND_WIDTH = $clog2(NUM_ROUNDS);

    // Expansion table: output bit i (DES numbering, 1-based) takes R bit E_TABLE[i-1]
    localparam int unsigned E_TABLE [K_WIDTH] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    typedef logic [CHUNK_WIDTH-1:0] sbox_idx_t;

    typedef struct packed {
        logic [K_WIDTH-1:0]     sbox_in;
        logic [ROUND_WIDTH-1:0] round_idx;
        logic                   last_round;
`ifdef DES_EXPAND_MIX_PARITY_EN
        logic [NUM_CHUNKS-1:0]  chunk_par;
`endif
    } mix_beat_t;

endpackage

// File: rtl/des_skid_reg.sv
// One-entry skid buffer over mix_beat_t; in_ready is registered and
// never depends combinationally on out_ready.
module des_skid_reg
    import des_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  mix_beat_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output mix_beat_t out_data
);

    logic      skid_valid;
    mix_beat_t skid_data;

    logic      accept_c;
    logic      main_valid_n;
    logic      skid_valid_n;
    mix_beat_t main_data_n;
    mix_beat_t skid_data_n;

    assign accept_c = in_valid && in_ready;

    // Main refills from skid first, otherwise from the input; skid only
    // captures when main is stuck.
    always_comb begin
        main_valid_n = out_valid;
        main_data_n  = out_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (!out_valid || out_ready) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end else begin
                main_valid_n = accept_c;
                if (accept_c) begin
                    main_data_n = in_data;
                end
            end
        end else if (accept_c) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= main_valid_n;
            out_data   <= main_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            in_ready   <= !skid_valid_n;
        end
    end

endmodule

// File: rtl/des_expand_mix.sv
// DES round front end: E expansion of R, XOR with subkey, round tagging,
// registered through a skid stage. DES_EXPAND_MIX_PARITY_EN adds chunk_par.
module des_expand_mix
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_first,
    input  logic [31:0] r_in,
    input  logic [47:0] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] sbox_in,
    output logic [3:0]  round_idx,
`ifdef DES_EXPAND_MIX_PARITY_EN
    output logic [7:0]  chunk_par,
`endif
    output logic        last_round
);

    logic [K_WIDTH-1:0]     expanded_c;
    logic [K_WIDTH-1:0]     mixed_c;
    logic [ROUND_WIDTH-1:0] round_cnt;
    logic [ROUND_WIDTH-1:0] beat_round_c;
    logic                   accept_c;
    mix_beat_t              in_beat_c;
    mix_beat_t              out_beat;

    // DES bit n lives at vector bit (width - n)
    always_comb begin
        expanded_c = '0;
        for (int i = 0; i < K_WIDTH; i++) begin
            expanded_c[6'(K_WIDTH - 1 - i)] = r_in[5'(R_WIDTH - E_TABLE[i])];
        end
        mixed_c = expanded_c ^ subkey;
    end

    assign accept_c     = in_valid && in_ready;
    assign beat_round_c = in_first ? '0 : round_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt <= '0;
        end else if (accept_c) begin
            round_cnt <= beat_round_c + ROUND_WIDTH'(1);
        end
    end

    always_comb begin
        in_beat_c            = '0;
        in_beat_c.sbox_in    = mixed_c;
        in_beat_c.round_idx  = beat_round_c;
        in_beat_c.last_round = (beat_round_c == ROUND_WIDTH'(NUM_ROUNDS - 1));
`ifdef DES_EXPAND_MIX_PARITY_EN
        for (int j = 0; j < NUM_CHUNKS; j++) begin
            in_beat_c.chunk_par[3'(j)] =
                ^sbox_idx_t'(mixed_c[6'(j * CHUNK_WIDTH) +: CHUNK_WIDTH]);
        end
`endif
    end

    des_skid_reg u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_beat_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_beat)
    );

    assign sbox_in    = out_beat.sbox_in;
    assign round_idx  = out_beat.round_idx;
    assign last_round = out_beat.last_round;
`ifdef DES_EXPAND_MIX_PARITY_EN
    assign chunk_par  = out_beat.chunk_par;
`endif

endmodule

// File: tb/tb_des_expand_mix.sv
// Self-checking bench for des_expand_mix against a behavioural reference model.
module tb_des_expand_mix;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_first, out_valid, out_ready, last_round;
    logic [31:0] r_in;
    logic [47:0] subkey, sbox_in;
    logic [3:0]  round_idx;
`ifdef DES_EXPAND_MIX_PARITY_EN
    logic [7:0]  chunk_par;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [47:0] s;
        logic [3:0]  r;
        logic        l;
    } beat_t;

    always #5 clk = ~clk;

    des_expand_mix dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_first   (in_first),
        .r_in       (r_in),
        .subkey     (subkey),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sbox_in    (sbox_in),
        .round_idx  (round_idx),
`ifdef DES_EXPAND_MIX_PARITY_EN
        .chunk_par  (chunk_par),
`endif
        .last_round (last_round)
    );

    // Chunk c (0-based) reads R bits 4c .. 4c+5 in DES numbering, wrapping 0->32, 33->1
    function automatic logic [47:0] ref_mix(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        int j;
        e = '0;
        for (int c = 0; c < 8; c++) begin
            for (int b = 0; b < 6; b++) begin
                j = ((4 * c + b - 1 + 32) % 32) + 1;
                e[6'(47 - (6 * c + b))] = r[5'(32 - j)];
            end
        end
        return e ^ k;
    endfunction

    function automatic logic [7:0] ref_par(input logic [47:0] x);
        logic [7:0] p;
        logic [5:0] ch;
        for (int j = 0; j < 8; j++) begin
            ch = x[6'(6 * j) +: 6];
            p[3'(j)] = ^ch;
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
        r_in = '0; subkey = '0;
        step();
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (sbox_in !== 48'h0 || round_idx !== 4'h0 || last_round !== 1'b0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%b exp=0/0/0", sbox_in, round_idx, last_round);
        end
`ifdef DES_EXPAND_MIX_PARITY_EN
        total++; if (chunk_par !== 8'h00) begin bad++; $display("FAIL reset_par got=%h exp=00", chunk_par); end
`endif
    endtask

    task automatic test_known_vector();
        logic [47:0] exp;
        logic [5:0]  ch5;
        in_valid = 1'b1; in_first = 1'b1; out_ready = 1'b1;
        r_in = 32'hF0AAF0AA; subkey = 48'h1B02EFFC7072;
        exp = ref_mix(r_in, subkey);
        step();
        in_valid = 1'b0; in_first = 1'b0;
        ch5 = sbox_in[23:18];
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL kv_valid got=%b exp=1", out_valid); end
        total++; if (sbox_in !== exp) begin bad++; $display("FAIL kv_sbox_in got=%h exp=%h", sbox_in, exp); end
        total++; if (ch5 !== 6'h21) begin bad++; $display("FAIL kv_chunk5 got=%h exp=21", ch5); end
        total++; if (round_idx !== 4'd0 || last_round !== 1'b0) begin
            bad++; $display("FAIL kv_round got=%0d/%b exp=0/0", round_idx, last_round);
        end
`ifdef DES_EXPAND_MIX_PARITY_EN
        total++; if (chunk_par !== ref_par(exp)) begin bad++; $display("FAIL kv_par got=%h exp=%h", chunk_par, ref_par(exp)); end
`endif
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kv_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_extremes();
        logic [31:0] rv [3];
        logic [47:0] kv [3];
        logic [47:0] ev [3];
        rv[0] = 32'h00000000; kv[0] = 48'h000000000000; ev[0] = 48'h000000000000;
        rv[1] = 32'hFFFFFFFF; kv[1] = 48'h000000000000; ev[1] = 48'hFFFFFFFFFFFF;
        rv[2] = 32'hFFFFFFFF; kv[2] = 48'hFFFFFFFFFFFF; ev[2] = 48'h000000000000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_first = 1'b1; r_in = rv[i]; subkey = kv[i];
            step();
            total++; if (out_valid !== 1'b1 || sbox_in !== ev[i]) begin
                bad++; $display("FAIL extreme_%0d got=%b/%h exp=1/%h", i, out_valid, sbox_in, ev[i]);
            end
        end
        in_valid = 1'b0; in_first = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] rv [4];
        logic [47:0] kv [4];
        int idx = 0;
        int held = 0;
        logic exp_rdy, acc, xfr;
        for (int i = 0; i < 4; i++) begin
            rv[i] = $urandom; kv[i] = {16'($urandom), 32'($urandom)};
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_first = (idx == 0); r_in = rv[idx]; subkey = kv[idx];
            acc = (held < 2);
            step();
            if (acc) begin idx++; held++; end
            total++; if (in_ready !== (c == 0)) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, (c == 0)); end
            total++; if (out_valid !== 1'b1 || sbox_in !== ref_mix(rv[0], kv[0])) begin
                bad++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, out_valid, sbox_in, ref_mix(rv[0], kv[0]));
            end
        end
        out_ready = 1'b1;
        for (int o = 0; o < 4; o++) begin
            total++; if (out_valid !== 1'b1 || sbox_in !== ref_mix(rv[o], kv[o]) || round_idx !== 4'(o)) begin
                bad++; $display("FAIL bp_drain_%0d got=%b/%h/%0d exp=1/%h/%0d", o, out_valid, sbox_in, round_idx, ref_mix(rv[o], kv[o]), o);
            end
            exp_rdy = (held < 2);
            total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp_rdy_%0d got=%b exp=%b", o, in_ready, exp_rdy); end
            in_valid = (idx < 4); in_first = 1'b0;
            if (idx < 4) begin r_in = rv[idx]; subkey = kv[idx]; end
            acc = in_valid && exp_rdy;
            xfr = (held > 0);
            step();
            held = held - int'(xfr) + int'(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_round_count();
        logic [47:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_first = (i == 0);
            r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
            exp = ref_mix(r_in, subkey);
            step();
            total++; if (out_valid !== 1'b1 || sbox_in !== exp || round_idx !== 4'(i % 16) || last_round !== (i == 15)) begin
                bad++; $display("FAIL round_%0d got=%b/%h/%0d/%b exp=1/%h/%0d/%b",
                                i, out_valid, sbox_in, round_idx, last_round, exp, i % 16, (i == 15));
            end
        end
        in_valid = 1'b0; in_first = 1'b0;
        step();
    endtask

    task automatic test_restart();
        logic [3:0] cnt = 4'd0;
        logic [3:0] r;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_first = (i == 0 || i == 5);
            r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
            r = in_first ? 4'd0 : cnt;
            cnt = 4'(r + 1);
            step();
            total++; if (round_idx !== r) begin bad++; $display("FAIL restart_%0d got=%0d exp=%0d", i, round_idx, r); end
        end
        in_valid = 1'b0; in_first = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [47:0] exp;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_first = (i == 0);
            r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
            step();
        end
        in_valid = 1'b0; in_first = 1'b0;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rm_full got=%b/%b exp=0/1", in_ready, out_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sbox_in !== 48'h0) begin
            bad++; $display("FAIL rm_after got=%b/%b/%h exp=0/1/0", out_valid, in_ready, sbox_in);
        end
`ifdef DES_EXPAND_MIX_PARITY_EN
        total++; if (chunk_par !== 8'h00) begin bad++; $display("FAIL rm_par got=%h exp=00", chunk_par); end
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
        exp = ref_mix(r_in, subkey);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || sbox_in !== exp || round_idx !== 4'd0) begin
            bad++; $display("FAIL rm_next got=%b/%h/%0d exp=1/%h/0", out_valid, sbox_in, round_idx, exp);
        end
        step();
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t nb;
        logic [3:0] cnt = 4'd0;
        logic acc, xfr;
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            total++; if (in_ready !== (q.size() < 2)) begin bad++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, in_ready, (q.size() < 2)); end
            total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, (q.size() != 0)); end
            if (q.size() != 0) begin
                total++; if (sbox_in !== q[0].s || round_idx !== q[0].r || last_round !== q[0].l) begin
                    bad++; $display("FAIL rnd_data c=%0d got=%h/%0d/%b exp=%h/%0d/%b", c, sbox_in, round_idx, last_round, q[0].s, q[0].r, q[0].l);
                end
`ifdef DES_EXPAND_MIX_PARITY_EN
                total++; if (chunk_par !== ref_par(q[0].s)) begin bad++; $display("FAIL rnd_par c=%0d got=%h exp=%h", c, chunk_par, ref_par(q[0].s)); end
`endif
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_first  = ($urandom_range(0, 9) == 0);
            r_in = $urandom; subkey = {16'($urandom), 32'($urandom)};
            acc = in_valid && (q.size() < 2);
            xfr = out_ready && (q.size() != 0);
            nb = '0;
            if (acc) begin
                nb.s = ref_mix(r_in, subkey);
                nb.r = in_first ? 4'd0 : cnt;
                nb.l = (nb.r == 4'd15);
                cnt  = 4'(nb.r + 1);
            end
            step();
            if (xfr) void'(q.pop_front());
            if (acc) q.push_back(nb);
        end
        in_valid = 1'b0; in_first = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_extremes();
        test_backpressure();
        test_round_count();
        test_restart();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
